// File: rtl/cpu_debug_pkg.sv
// Shared constants for the CPU debug scanner: FSM encoding, frame lengths, ASCII glyphs.
package cpu_debug_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned FRAME_BIN   = 5;
  localparam int unsigned FRAME_ASCII = 12;

  localparam logic [BYTE_W-1:0] ASCII_COLON = 8'h3A;
  localparam logic [BYTE_W-1:0] ASCII_NL    = 8'h0A;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_ADDR  = 3'd1;
  localparam logic [STATE_W-1:0] ST_LATCH = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND  = 3'd3;
  localparam logic [STATE_W-1:0] ST_FIN   = 3'd4;

endpackage

// File: rtl/reg_dump_scanner_if.sv
// Control, register-file debug port and byte stream of the register dump scanner.
interface reg_dump_scanner_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  // Scanner side
  modport master (
    input  start, first_addr, last_addr, dbg_data, tx_ready,
    output dbg_addr, tx_data, tx_valid, busy, done
  );

  // Requester / register file / sink side
  modport slave (
    output start, first_addr, last_addr, dbg_data, tx_ready,
    input  dbg_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/nibble_to_ascii.sv
// Combinational hex digit to uppercase ASCII ('0'..'9', 'A'..'F').
// Only present when REG_DUMP_ASCII_EN is defined.
`ifdef REG_DUMP_ASCII_EN
module nibble_to_ascii (
  input  logic [3:0] nib,
  output logic [7:0] ascii_c
);
  // 'A' - 10 = 0x37
  assign ascii_c = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
endmodule
`endif

// File: rtl/reg_dump_scanner.sv
// Walks a register range on the debug read port and streams each value as bytes.
// Binary 5-byte frames by default; REG_DUMP_ASCII_EN selects 12-byte "RR:HHHHHHHH\n" frames.
module reg_dump_scanner
  import cpu_debug_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input logic                clk,
  input logic                rst,
  reg_dump_scanner_if.master bus
);

`ifdef REG_DUMP_ASCII_EN
  localparam int unsigned FRAME_LEN = FRAME_ASCII;
`else
  localparam int unsigned FRAME_LEN = FRAME_BIN;
`endif
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  cur_q, cur_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic [ADDR_W-1:0]  dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0]  snap_q, snap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   sel_idx;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [BYTE_W-1:0]  frame_byte;
  logic [BYTE_W-1:0]  cur_byte;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Index of the byte to load next: byte 0 while latching, otherwise the one after the current
  assign sel_idx  = (state_q == ST_SEND) ? (idx_q + IDX_W'(1)) : '0;
  assign cur_byte = BYTE_W'(cur_q);

`ifdef REG_DUMP_ASCII_EN
  logic [3:0]        nib;
  logic [BYTE_W-1:0] hex_char;

  // Pick the nibble rendered at sel_idx (address digits, then snapshot MSB first)
  always_comb begin
    nib = 4'h0;
    case (sel_idx)
      4'd0:    nib = cur_byte[7:4];
      4'd1:    nib = cur_byte[3:0];
      4'd3:    nib = snap_q[31:28];
      4'd4:    nib = snap_q[27:24];
      4'd5:    nib = snap_q[23:20];
      4'd6:    nib = snap_q[19:16];
      4'd7:    nib = snap_q[15:12];
      4'd8:    nib = snap_q[11:8];
      4'd9:    nib = snap_q[7:4];
      4'd10:   nib = snap_q[3:0];
      default: nib = 4'h0;
    endcase
  end

  nibble_to_ascii u_hex (
    .nib     (nib),
    .ascii_c (hex_char)
  );

  // Frame byte: fixed separators or a hex digit
  always_comb begin
    case (sel_idx)
      4'd2:    frame_byte = ASCII_COLON;
      4'd11:   frame_byte = ASCII_NL;
      default: frame_byte = hex_char;
    endcase
  end
`else
  // Frame byte: zero-extended address, then snapshot MSB first
  always_comb begin
    case (sel_idx)
      4'd0:    frame_byte = cur_byte;
      4'd1:    frame_byte = snap_q[31:24];
      4'd2:    frame_byte = snap_q[23:16];
      4'd3:    frame_byte = snap_q[15:8];
      4'd4:    frame_byte = snap_q[7:0];
      default: frame_byte = '0;
    endcase
  end
`endif

  // Next-state and next-output logic; outputs are registered below
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    dbg_addr_d = dbg_addr_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cur_d   = bus.first_addr;
          end_d   = bus.last_addr;
          busy_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        dbg_addr_d = cur_q;
        state_d    = ST_LATCH;
      end
      ST_LATCH: begin
        // Atomic capture; later register writes do not affect this frame
        snap_d     = bus.dbg_data;
        idx_d      = '0;
        tx_data_d  = frame_byte;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            if (cur_q == end_q) begin
              done_d  = 1'b1;
              state_d = ST_FIN;
            end else begin
              cur_d   = (cur_q == TOP_ADDR) ? '0 : (cur_q + ADDR_W'(1));
              state_d = ST_ADDR;
            end
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = frame_byte;
          end
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      dbg_addr_q <= '0;
      snap_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      dbg_addr_q <= dbg_addr_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.dbg_addr = dbg_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: register-file model, byte-stream monitor and frame reference model.
module tb_reg_dump_scanner;

`ifdef REG_DUMP_ASCII_EN
  localparam int FRAME = 12;
`else
  localparam int FRAME = 5;
`endif
  localparam int NREG = 32;

  logic clk;
  logic rst;
  logic [31:0] regs [NREG];

  reg_dump_scanner_if #(.ADDR_W(5)) bus ();

  reg_dump_scanner #(.NUM_REGS(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.dbg_data = regs[bus.dbg_addr];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int exp_cnt  = 0;
  bit stall_en = 0;

  logic [7:0] exp_q [$];
  logic [7:0] rcv_q [$];
  int         tcyc_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n) - 8'd10;
  endfunction

  // Expected frame for one register: defined directly from the frame layout
  function automatic void push_frame(input int a, input logic [31:0] v);
    logic [7:0] ab;
    ab = 8'(a);
`ifdef REG_DUMP_ASCII_EN
    exp_q.push_back(hexc(ab[7:4]));
    exp_q.push_back(hexc(ab[3:0]));
    exp_q.push_back(8'h3A);
    for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(4'(v >> (4 * k))));
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(ab);
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'(v >> (8 * k)));
`endif
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Sink: drives tx_ready just after each rising edge
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Monitor: records transfers and checks hold-while-stalled on the falling edge
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(bus.tx_valid), 32'd1);
          check("hold_data", 32'(bus.tx_data), 32'(prev_data));
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
          rcv_q.push_back(bus.tx_data);
          tcyc_q.push_back(cyc);
        end
        prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
        prev_data  = bus.tx_data;
        if (bus.done === 1'b1) done_cnt++;
      end
    end
  end

  task automatic start_dump(input int f, input int l);
    int n;
    exp_q.delete();
    rcv_q.delete();
    tcyc_q.delete();
    done_cnt = 0;
    n = ((l - f + NREG) % NREG) + 1;
    exp_cnt = FRAME * n;
    for (int k = 0; k < n; k++) push_frame((f + k) % NREG, regs[(f + k) % NREG]);
    @(posedge clk);
    #1;
    bus.first_addr = 5'(f);
    bus.last_addr  = 5'(l);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic finish_dump(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_busy_in_fin"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
      check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    end
    check({tag, "_byte_count"}, 32'(rcv_q.size()), 32'(exp_cnt));
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rcv_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_dbg_addr"}, 32'(bus.dbg_addr), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
  endtask

  initial begin
    bit reached;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_released");

    // Single register, full-rate sink
    regs[5] = 32'hDEADBEEF;
    start_dump(5, 5);
    finish_dump("single", 100);
    if (tcyc_q.size() == FRAME)
      check("single_back_to_back", 32'(tcyc_q[FRAME-1] - tcyc_q[0]), 32'(FRAME - 1));

    // Wrap-around range 30..1
    regs[30] = 32'h11;
    regs[31] = 32'h22;
    regs[0]  = 32'h0;
    regs[1]  = 32'h44;
    start_dump(30, 1);
    finish_dump("wrap", 300);
    if (tcyc_q.size() > FRAME)
      check("wrap_frame_gap", 32'(tcyc_q[FRAME] - tcyc_q[FRAME-1]), 32'd3);

    // Full dump with a stalling sink
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    stall_en = 1;
    start_dump(0, 31);
    finish_dump("stall_full", FRAME * 32 * 12 + 200);
    stall_en = 0;

    // Write to r7 right after it is latched
    regs[7] = 32'h1;
    start_dump(7, 7);
    @(posedge clk);
    @(posedge clk);
    #1;
    regs[7] = 32'h2;
    finish_dump("snap_atomic", 100);
    start_dump(7, 7);
    finish_dump("snap_next", 100);

    // Reset in the middle of frame 3, byte 2
    start_dump(0, 31);
    reached = 0;
    for (int n = 0; n < 400 && !reached; n++) begin
      @(negedge clk);
      #1;
      if (rcv_q.size() >= 2 * FRAME + 2) reached = 1;
    end
    check("midreset_reached", 32'(reached), 32'd1);
    @(posedge clk);
    #1;
    check("midreset_valid_before", 32'(bus.tx_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midreset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_dump(0, 0);
    finish_dump("after_reset", 100);

    // Random ranges against a stalling sink
    stall_en = 1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NREG; i++) regs[i] = $urandom;
      start_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      finish_dump($sformatf("rand%0d", t), exp_cnt * 12 + 200);
    end
    stall_en = 0;

`ifdef REG_DUMP_ASCII_EN
    regs[10] = 32'h00AB12CD;
    start_dump(10, 10);
    finish_dump("ascii", 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
